// File: rtl/lieat_exu_vpu_vseq16.sv
// Element sequencer in front of the 16-bit vector ALU lane: issues vl element pairs, packs lane results, keeps tail elements.
// Optional vector-scalar operand form (.vx) is built when LIEAT_VPU_VX_EN is defined.
module lieat_exu_vpu_vseq16 #(
  parameter int VLEN = 128,
  parameter int ELEN = 16,
  parameter int VLW  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            seq_i_valid,
  output logic            seq_i_ready,
  input  logic [VLEN-1:0] seq_i_vs1,
  input  logic [VLEN-1:0] seq_i_vs2,
  input  logic [VLEN-1:0] seq_i_old_vd,
  input  logic [VLW-1:0]  seq_i_vl,
  input  logic [4:0]      seq_i_vd_idx,
  input  logic            seq_i_vadd,
  input  logic            seq_i_vsub,
  input  logic            seq_i_vrsub,
`ifdef LIEAT_VPU_VX_EN
  input  logic            seq_i_vx,
  input  logic [ELEN-1:0] seq_i_rs1,
`endif
  output logic            vunit_valid,
  output logic [ELEN-1:0] vunit_op1,
  output logic [ELEN-1:0] vunit_op2,
  output logic            vunit_vadd,
  output logic            vunit_vsub,
  output logic            vunit_vrsub,
  input  logic            vunit_o_valid,
  input  logic [ELEN-1:0] vunit_o_data,
  output logic            seq_o_valid,
  input  logic            seq_o_ready,
  output logic [VLEN-1:0] seq_o_vd,
  output logic [4:0]      seq_o_vd_idx
);

  localparam int NELEM = VLEN / ELEN;
  localparam int IW    = $clog2(NELEM);
  localparam logic [VLW-1:0] VL_MAX = VLW'(NELEM);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        w_accept;
  logic                        w_lane_wr;
  logic [VLW-1:0]              w_vl_clamp;
  logic [IW-1:0]               r_idx;
  logic [VLW-1:0]              r_vl;
  logic [4:0]                  r_vd_idx;
  logic                        r_vadd;
  logic                        r_vsub;
  logic                        r_vrsub;
  logic [NELEM-1:0][ELEN-1:0]  r_vs1;
  logic [NELEM-1:0][ELEN-1:0]  r_vs2;
  logic [NELEM-1:0][ELEN-1:0]  r_res;
`ifdef LIEAT_VPU_VX_EN
  logic                        r_vx;
  logic [ELEN-1:0]             r_rs1;
`endif

  assign w_vl_clamp = (seq_i_vl > VL_MAX) ? VL_MAX : seq_i_vl;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    seq_i_ready = 1'b0;
    vunit_valid = 1'b0;
    seq_o_valid = 1'b0;
    w_accept    = 1'b0;
    w_lane_wr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        seq_i_ready = 1'b1;
        if (seq_i_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_vl_clamp == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        vunit_valid = 1'b1;
        // A low lane valid is a stall: index holds and the same element is re-issued.
        if (vunit_o_valid) begin
          w_lane_wr = 1'b1;
          if (VLW'(r_idx) == r_vl - VLW'(1)) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        seq_o_valid = 1'b1;
        if (seq_o_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result register starts as old_vd so elements at or beyond vl stay undisturbed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx    <= '0;
      r_vl     <= '0;
      r_vd_idx <= '0;
      r_vadd   <= 1'b0;
      r_vsub   <= 1'b0;
      r_vrsub  <= 1'b0;
      r_res    <= '0;
`ifdef LIEAT_VPU_VX_EN
      r_vx     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_idx    <= '0;
      r_vl     <= w_vl_clamp;
      r_vd_idx <= seq_i_vd_idx;
      r_vadd   <= seq_i_vadd;
      r_vsub   <= seq_i_vsub;
      r_vrsub  <= seq_i_vrsub;
      r_res    <= seq_i_old_vd;
`ifdef LIEAT_VPU_VX_EN
      r_vx     <= seq_i_vx;
`endif
    end else if (w_lane_wr) begin
      r_res[r_idx] <= vunit_o_data;
      r_idx        <= r_idx + IW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_vs1 <= seq_i_vs1;
      r_vs2 <= seq_i_vs2;
`ifdef LIEAT_VPU_VX_EN
      r_rs1 <= seq_i_rs1;
`endif
    end
  end

  assign vunit_op1 = r_vs2[r_idx];
`ifdef LIEAT_VPU_VX_EN
  assign vunit_op2 = r_vx ? r_rs1 : r_vs1[r_idx];
`else
  assign vunit_op2 = r_vs1[r_idx];
`endif
  assign vunit_vadd   = r_vadd;
  assign vunit_vsub   = r_vsub;
  assign vunit_vrsub  = r_vrsub;
  assign seq_o_vd     = r_res;
  assign seq_o_vd_idx = r_vd_idx;

endmodule

// File: tb/tb_lieat_exu_vpu_vseq16.sv
// Scoreboard bench for lieat_exu_vpu_vseq16 with a combinational lane model that can inject stalls.
module tb_lieat_exu_vpu_vseq16;

  localparam logic [127:0] VS2_SEQ  = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
  localparam logic [127:0] VS1_10   = {8{16'h0010}};
  localparam logic [127:0] ADD_EXP  = 128'h0018_0017_0016_0015_0014_0013_0012_0011;
  localparam logic [127:0] RSUB_EXP = 128'h0008_0009_000A_000B_000C_000D_000E_000F;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         seq_i_valid, seq_i_ready;
  logic [127:0] seq_i_vs1, seq_i_vs2, seq_i_old_vd;
  logic [3:0]   seq_i_vl;
  logic [4:0]   seq_i_vd_idx;
  logic         seq_i_vadd, seq_i_vsub, seq_i_vrsub;
  logic         vunit_valid;
  logic [15:0]  vunit_op1, vunit_op2;
  logic         vunit_vadd, vunit_vsub, vunit_vrsub;
  logic         vunit_o_valid;
  logic [15:0]  vunit_o_data;
  logic         seq_o_valid, seq_o_ready;
  logic [127:0] seq_o_vd;
  logic [4:0]   seq_o_vd_idx;
  logic         w_stall;

  typedef struct {
    logic [127:0] vd;
    logic [4:0]   idx;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  int   ntests = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   elem_cnt = 0;
  int   stall_cnt = 0;
  int   issue_cnt = 0;
  int   xfers = 0;
  int   stall_elem = -1;
  int   stall_len = 0;
  bit   seen = 1'b0;

  always #5 clock = ~clock;

  lieat_exu_vpu_vseq16 dut (
    .clock(clock), .reset(reset),
    .seq_i_valid(seq_i_valid), .seq_i_ready(seq_i_ready),
    .seq_i_vs1(seq_i_vs1), .seq_i_vs2(seq_i_vs2), .seq_i_old_vd(seq_i_old_vd),
    .seq_i_vl(seq_i_vl), .seq_i_vd_idx(seq_i_vd_idx),
    .seq_i_vadd(seq_i_vadd), .seq_i_vsub(seq_i_vsub), .seq_i_vrsub(seq_i_vrsub),
    .vunit_valid(vunit_valid), .vunit_op1(vunit_op1), .vunit_op2(vunit_op2),
    .vunit_vadd(vunit_vadd), .vunit_vsub(vunit_vsub), .vunit_vrsub(vunit_vrsub),
    .vunit_o_valid(vunit_o_valid), .vunit_o_data(vunit_o_data),
    .seq_o_valid(seq_o_valid), .seq_o_ready(seq_o_ready),
    .seq_o_vd(seq_o_vd), .seq_o_vd_idx(seq_o_vd_idx)
  );

  // Lane model: combinational, zero result when no op select is set.
  always_comb begin
    vunit_o_data = 16'h0000;
    if (vunit_vadd)       vunit_o_data = vunit_op1 + vunit_op2;
    else if (vunit_vsub)  vunit_o_data = vunit_op1 - vunit_op2;
    else if (vunit_vrsub) vunit_o_data = vunit_op2 - vunit_op1;
  end

  assign w_stall       = (elem_cnt == stall_elem) && (stall_cnt < stall_len);
  assign vunit_o_valid = vunit_valid && !w_stall;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (vunit_valid) issue_cnt <= issue_cnt + 1;
    if (seq_i_ready) begin
      elem_cnt  <= 0;
      stall_cnt <= 0;
    end else if (vunit_valid) begin
      if (w_stall) stall_cnt <= stall_cnt + 1;
      else         elem_cnt  <= elem_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t d;
    if (vunit_valid && w_stall) begin
      chk("stall_op1", 128'(vunit_op1), 128'h5);
      chk("stall_op2", 128'(vunit_op2), 128'h10);
    end
    if (seq_o_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_o_valid", 128'(seq_o_valid), 128'h0);
      end else begin
        chk("o_vd", seq_o_vd, sb_q[0].vd);
        chk("o_vd_idx", 128'(seq_o_vd_idx), 128'(sb_q[0].idx));
        if (!seen) chk("o_valid_cycle", 128'(cyc), 128'(sb_q[0].cyc));
        seen = 1'b1;
        if (seq_o_ready) begin
          d = sb_q.pop_front();
          seen = 1'b0;
          xfers++;
        end
      end
    end
  end

  task automatic issue(input logic [127:0] vs1, input logic [127:0] vs2, input logic [127:0] old,
                       input logic [3:0] vl, input logic [4:0] vdi, input logic [2:0] op,
                       input logic [127:0] exp, input int lat, input bit push);
    int   t = 0;
    exp_t e;
    seq_i_vs1    = vs1;
    seq_i_vs2    = vs2;
    seq_i_old_vd = old;
    seq_i_vl     = vl;
    seq_i_vd_idx = vdi;
    {seq_i_vadd, seq_i_vsub, seq_i_vrsub} = op;
    seq_i_valid  = 1'b1;
    while (!seq_i_ready && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    if (!seq_i_ready) begin
      chk("accept_timeout", 128'(seq_i_ready), 128'h1);
    end else if (push) begin
      e.vd  = exp;
      e.idx = vdi;
      e.cyc = cyc + lat;
      sb_q.push_back(e);
    end
    @(posedge clock); #1;
    seq_i_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(posedge clock); #1;
      t++;
    end
    chk("done_timeout", 128'(sb_q.size()), 128'h0);
  endtask

  initial begin
    int n0;
    int x0;
    int t;
    seq_i_valid = 1'b0;
    seq_i_vs1 = '0; seq_i_vs2 = '0; seq_i_old_vd = '0;
    seq_i_vl = '0; seq_i_vd_idx = '0;
    seq_i_vadd = 1'b0; seq_i_vsub = 1'b0; seq_i_vrsub = 1'b0;
    seq_o_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_i_ready", 128'(seq_i_ready), 128'h1);
    chk("rst_o_valid", 128'(seq_o_valid), 128'h0);
    chk("rst_vunit_valid", 128'(vunit_valid), 128'h0);
    chk("rst_o_vd", seq_o_vd, 128'h0);
    chk("rst_o_vd_idx", 128'(seq_o_vd_idx), 128'h0);
    chk("rst_ops", 128'({vunit_vadd, vunit_vsub, vunit_vrsub}), 128'h0);

    // vadd, full length
    issue(VS1_10, VS2_SEQ, {8{16'hC0DE}}, 4'd8, 5'd3, 3'b100, ADD_EXP, 9, 1'b1);
    wait_done();

    // vsub with wrap, tail undisturbed
    issue({8{16'h0001}}, 128'h0, {8{16'hAAAA}}, 4'd3, 5'd4, 3'b010,
          128'hAAAA_AAAA_AAAA_AAAA_AAAA_FFFF_FFFF_FFFF, 4, 1'b1);
    wait_done();

    // vl = 0: straight to DONE, nothing issued to the lane
    n0 = issue_cnt;
    issue(VS1_10, VS2_SEQ, {8{16'h1234}}, 4'd0, 5'd5, 3'b100, {8{16'h1234}}, 1, 1'b1);
    wait_done();
    chk("vl0_no_issue", 128'(issue_cnt - n0), 128'h0);

    // vrsub, vl clamped to 8, writeback back-pressure
    seq_o_ready = 1'b0;
    x0 = xfers;
    issue(VS1_10, VS2_SEQ, {8{16'h7777}}, 4'd12, 5'd9, 3'b001, RSUB_EXP, 9, 1'b1);
    t = 0;
    while (!seq_o_valid && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    repeat (5) @(posedge clock);
    #1 seq_o_ready = 1'b1;
    @(posedge clock); #1;
    chk("hold_one_xfer", 128'(xfers - x0), 128'h1);
    chk("hold_ready_after", 128'(seq_i_ready), 128'h1);
    chk("hold_o_valid_drop", 128'(seq_o_valid), 128'h0);
    wait_done();

    // lane stall at element 4 for 2 cycles
    stall_elem = 4;
    stall_len  = 2;
    issue(VS1_10, VS2_SEQ, 128'h0, 4'd8, 5'd12, 3'b100, ADD_EXP, 11, 1'b1);
    wait_done();
    stall_elem = -1;
    stall_len  = 0;

    // no op select: active elements become zero
    issue(VS1_10, VS2_SEQ, {8{16'h5555}}, 4'd2, 5'd17, 3'b000,
          128'h5555_5555_5555_5555_5555_5555_0000_0000, 3, 1'b1);
    wait_done();

    // reset mid-RUN abandons the instruction
    issue(VS1_10, VS2_SEQ, {8{16'h9999}}, 4'd8, 5'd7, 3'b100, ADD_EXP, 9, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("run_op1_idx2", 128'(vunit_op1), 128'h3);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mid_rst_o_valid", 128'(seq_o_valid), 128'h0);
    chk("mid_rst_vunit_valid", 128'(vunit_valid), 128'h0);
    chk("mid_rst_i_ready", 128'(seq_i_ready), 128'h1);
    chk("mid_rst_o_vd", seq_o_vd, 128'h0);
    reset = 1'b0;

    issue(VS1_10, VS2_SEQ, {8{16'hBEEF}}, 4'd5, 5'd21, 3'b100,
          128'hBEEF_BEEF_BEEF_0015_0014_0013_0012_0011, 6, 1'b1);
    wait_done();
    repeat (3) @(posedge clock);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
